// File: rtl/pc_predict_pkg.sv
// Shared types for the fetch-PC predictor: counter and jump encodings, BTB entry, counter helpers.
package pc_predict_pkg;

  // Entry fields are sized for the widest supported address; narrower configs zero-extend.
  localparam int unsigned BTB_MAX_W = 64;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_DIR  = 2'b01,
    JMP_REG  = 2'b10,
    JMP_RSV  = 2'b11
  } jump_e;

  typedef struct packed {
    logic                 valid;
    logic [BTB_MAX_W-1:0] tag;
    logic [BTB_MAX_W-1:0] target;
    ctr_e                 ctr;
  } btb_entry_t;

  function automatic ctr_e ctr_inc(input ctr_e c);
    return (c == ST) ? ST : ctr_e'(c + 2'd1);
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/pc_predict_unit_btb.sv
// Direct-mapped BTB with 2-bit counters: combinational read port, update applied at the clock edge.
module btb_table
  import pc_predict_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned TAG_W  = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [TAG_W-1:0]  rd_tag_i,
  output logic              rd_hit_o,
  output logic [ADDR_W-1:0] rd_target_o,
  output ctr_e              rd_ctr_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic              wr_taken_i,
  input  logic [ADDR_W-1:0] wr_target_i
);

  localparam int unsigned N = 1 << IDX_W;

  btb_entry_t mem_q [N];
  btb_entry_t rd_e;
  btb_entry_t wr_old;
  btb_entry_t wr_new_d;
  logic       wr_hit;
  logic       wr_we_d;

  always_comb begin
    rd_e        = mem_q[rd_idx_i];
    rd_hit_o    = rd_e.valid && (TAG_W'(rd_e.tag) == rd_tag_i);
    rd_target_o = ADDR_W'(rd_e.target);
    rd_ctr_o    = rd_e.ctr;
  end

  always_comb begin
    wr_old   = mem_q[wr_idx_i];
    wr_hit   = wr_old.valid && (TAG_W'(wr_old.tag) == wr_tag_i);
    wr_new_d = wr_old;
    wr_we_d  = 1'b0;
    if (wr_en_i && wr_hit) begin
      wr_we_d         = 1'b1;
      wr_new_d.ctr    = wr_taken_i ? ctr_inc(wr_old.ctr) : ctr_dec(wr_old.ctr);
      wr_new_d.target = BTB_MAX_W'(wr_target_i);
    end else if (wr_en_i && wr_taken_i) begin
      wr_we_d         = 1'b1;
      wr_new_d.valid  = 1'b1;
      wr_new_d.tag    = BTB_MAX_W'(wr_tag_i);
      wr_new_d.target = BTB_MAX_W'(wr_target_i);
      wr_new_d.ctr    = WT;
    end
  end

  // Only valid bits are reset; stale tag/target/ctr are unreachable until reallocated.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) mem_q[i].valid <= 1'b0;
    end else if (wr_we_d) begin
      mem_q[wr_idx_i] <= wr_new_d;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-PC controller: PC register, ID-stage resolve/redirect, misprediction counter.
// BTB prediction is built only when PC_PREDICT_BTB_EN is defined; otherwise static not-taken.
module pc_predict_unit
  import pc_predict_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       IDX_W    = 4,
  parameter int unsigned       TAG_W    = ADDR_W - IDX_W - 2,
  parameter int unsigned       CNT_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0040_0000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] PC_next,
  output logic              if_pred_taken,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              id_pred_taken,
  input  logic [1:0]        Jump,
  input  logic              Branch,
  input  logic              BranchCond,
  input  logic [ADDR_W-1:0] JumpTarget,
  input  logic [ADDR_W-1:0] branchCmpA,
  output logic              IFIDFlush,
  output logic              IDEXFlush,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  logic [ADDR_W-1:0] pc_q, pc_d, tgt, seq_pc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              taken, mispredict, pred_taken;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [TAG_W-1:0]  rd_tag, wr_tag;
  logic              wr_en;

  // pc already holds the successor of the ID instruction, so one compare catches every mispredict.
  always_comb begin
    taken      = (Jump == JMP_DIR) || (Jump == JMP_REG) || (Branch && BranchCond);
    tgt        = (Jump == JMP_REG) ? branchCmpA : (taken ? JumpTarget : id_pc + ADDR_W'(4));
    mispredict = id_valid && !stall && (pc_q != tgt);
  end

  assign rd_idx = pc_q[IDX_W+1:2];
  assign rd_tag = pc_q[IDX_W+2+TAG_W-1:IDX_W+2];
  assign wr_idx = id_pc[IDX_W+1:2];
  assign wr_tag = id_pc[IDX_W+2+TAG_W-1:IDX_W+2];
  assign wr_en  = id_valid && !stall && (Branch || (Jump == JMP_DIR)) && (Jump != JMP_REG);

`ifdef PC_PREDICT_BTB_EN
  logic              btb_hit;
  logic [ADDR_W-1:0] btb_target;
  ctr_e              btb_ctr;

  btb_table #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .rd_idx_i    (rd_idx),
    .rd_tag_i    (rd_tag),
    .rd_hit_o    (btb_hit),
    .rd_target_o (btb_target),
    .rd_ctr_o    (btb_ctr),
    .wr_en_i     (wr_en),
    .wr_idx_i    (wr_idx),
    .wr_tag_i    (wr_tag),
    .wr_taken_i  (taken),
    .wr_target_i (JumpTarget)
  );

  assign pred_taken = btb_hit && ((btb_ctr == WT) || (btb_ctr == ST));
  assign seq_pc     = pred_taken ? btb_target : pc_q + ADDR_W'(4);
`else
  logic unused_btb;
  assign unused_btb = ^{rd_idx, rd_tag, wr_idx, wr_tag, wr_en};
  assign pred_taken = 1'b0;
  assign seq_pc     = pc_q + ADDR_W'(4);
`endif

  // The prediction bit travels down the pipe for other consumers; resolution here does not need it.
  logic unused_id_pred;
  assign unused_id_pred = id_pred_taken;

  always_comb begin
    pc_d  = seq_pc;
    cnt_d = cnt_q;
    if (stall)           pc_d = pc_q;
    else if (mispredict) pc_d = tgt;
    if (mispredict)      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign pc             = pc_q;
  assign PC_next        = pc_d;
  assign if_pred_taken  = pred_taken;
  assign IFIDFlush      = mispredict && !reset;
  assign IDEXFlush      = stall && !reset;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed self-checking bench for pc_predict_unit; expectations adapt to PC_PREDICT_BTB_EN.
module tb_pc_predict_unit;

`ifdef PC_PREDICT_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif
  localparam int unsigned CNT_W = 4;

  logic              clk = 1'b0;
  logic              reset, stall;
  logic [31:0]       pc, PC_next;
  logic              if_pred_taken;
  logic              id_valid, id_pred_taken;
  logic [31:0]       id_pc, JumpTarget, branchCmpA;
  logic [1:0]        Jump;
  logic              Branch, BranchCond;
  logic              IFIDFlush, IDEXFlush;
  logic [CNT_W-1:0]  mispredict_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;
  logic [31:0] p_hold;

  always #5 clk = ~clk;

  pc_predict_unit #(
    .ADDR_W   (32),
    .IDX_W    (4),
    .CNT_W    (CNT_W),
    .RESET_PC (32'h0040_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .pc             (pc),
    .PC_next        (PC_next),
    .if_pred_taken  (if_pred_taken),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_pred_taken  (id_pred_taken),
    .Jump           (Jump),
    .Branch         (Branch),
    .BranchCond     (BranchCond),
    .JumpTarget     (JumpTarget),
    .branchCmpA     (branchCmpA),
    .IFIDFlush      (IFIDFlush),
    .IDEXFlush      (IDEXFlush),
    .mispredict_cnt (mispredict_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] ipc, input logic [1:0] j,
                        input logic br, input logic cond, input logic [31:0] jt,
                        input logic [31:0] ra);
    id_valid = v; id_pc = ipc; Jump = j; Branch = br; BranchCond = cond;
    JumpTarget = jt; branchCmpA = ra; id_pred_taken = 1'b0;
  endtask

  task automatic clear_id();
    set_id(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; stall = 1'b1; clear_id();
    #2;
    check_eq("idex_forced_in_reset", IDEXFlush, 0);
    tick();
    reset = 1'b0; stall = 1'b0;
    #1;
    check_eq("rst_pc", pc, 32'h0040_0000);
    check_eq("rst_cnt", mispredict_cnt, 0);
    check_eq("rst_pred", if_pred_taken, 0);
    check_eq("rst_ifid", IFIDFlush, 0);
    check_eq("rst_idex", IDEXFlush, 0);
    check_eq("rst_pcnext", PC_next, 32'h0040_0004);

    repeat (5) tick();
    check_eq("seq_pc", pc, 32'h0040_0014);

    // cold taken branch at 0x10 -> 0x40
    set_id(1'b1, 32'h0040_0010, 2'b00, 1'b1, 1'b1, 32'h0040_0040, 32'h0);
    #1;
    check_eq("cold_ifid", IFIDFlush, 1);
    check_eq("cold_pcnext", PC_next, 32'h0040_0040);
    tick(); clear_id(); exp_cnt++;
    #1;
    check_eq("cold_pc", pc, 32'h0040_0040);
    check_eq("cold_cnt", mispredict_cnt, 32'(exp_cnt % 16));

    // direct jump back to 0x10
    set_id(1'b1, 32'h0040_0030, 2'b01, 1'b0, 1'b0, 32'h0040_0010, 32'h0);
    #1;
    check_eq("jmp_ifid", IFIDFlush, 1);
    check_eq("jmp_pcnext", PC_next, 32'h0040_0010);
    tick(); clear_id(); exp_cnt++;
    #1;
    check_eq("jmp_pc", pc, 32'h0040_0010);
    check_eq("jmp_cnt", mispredict_cnt, 32'(exp_cnt % 16));
    check_eq("warm_pred", if_pred_taken, BTB ? 32'd1 : 32'd0);
    check_eq("warm_pcnext", PC_next, BTB ? 32'h0040_0040 : 32'h0040_0014);
    tick();
    check_eq("warm_pc", pc, BTB ? 32'h0040_0040 : 32'h0040_0014);

    // branch at 0x10 resolves not taken
    set_id(1'b1, 32'h0040_0010, 2'b00, 1'b1, 1'b0, 32'h0040_0040, 32'h0);
    #1;
    check_eq("nt_ifid", IFIDFlush, BTB ? 32'd1 : 32'd0);
    check_eq("nt_pcnext", PC_next, BTB ? 32'h0040_0014 : 32'h0040_0018);
    tick(); clear_id();
    if (BTB) exp_cnt++;
    p_hold = BTB ? 32'h0040_0014 : 32'h0040_0018;
    #1;
    check_eq("nt_pc", pc, p_hold);
    check_eq("nt_cnt", mispredict_cnt, 32'(exp_cnt % 16));

    // pending redirect held by stall
    stall = 1'b1;
    set_id(1'b1, 32'h0040_0030, 2'b01, 1'b0, 1'b0, 32'h0040_0010, 32'h0);
    #1;
    check_eq("stall_pcnext", PC_next, p_hold);
    check_eq("stall_ifid", IFIDFlush, 0);
    check_eq("stall_idex", IDEXFlush, 1);
    tick();
    check_eq("stall_pc", pc, p_hold);
    check_eq("stall_cnt", mispredict_cnt, 32'(exp_cnt % 16));
    stall = 1'b0;
    #1;
    check_eq("unstall_ifid", IFIDFlush, 1);
    check_eq("unstall_idex", IDEXFlush, 0);
    check_eq("unstall_pcnext", PC_next, 32'h0040_0010);
    tick(); clear_id(); exp_cnt++;
    #1;
    check_eq("unstall_cnt", mispredict_cnt, 32'(exp_cnt % 16));
    check_eq("unstall_pc", pc, 32'h0040_0010);
    check_eq("wnt_pred", if_pred_taken, 0);
    check_eq("wnt_pcnext", PC_next, 32'h0040_0014);
    tick();

    // register jump from 0x20 must not allocate even with Branch set
    set_id(1'b1, 32'h0040_0020, 2'b10, 1'b1, 1'b1, 32'h0040_0020, 32'h0040_0100);
    #1;
    check_eq("rj_ifid", IFIDFlush, 1);
    check_eq("rj_pcnext", PC_next, 32'h0040_0100);
    tick(); clear_id(); exp_cnt++;
    #1;
    check_eq("rj_pc", pc, 32'h0040_0100);
    check_eq("rj_cnt", mispredict_cnt, 32'(exp_cnt % 16));
    set_id(1'b1, 32'h0040_0034, 2'b01, 1'b0, 1'b0, 32'h0040_0020, 32'h0);
    tick(); clear_id(); exp_cnt++;
    #1;
    check_eq("rj_noalloc_pc", pc, 32'h0040_0020);
    check_eq("rj_noalloc_pred", if_pred_taken, 0);
    check_eq("rj_noalloc_pcnext", PC_next, 32'h0040_0024);

    // 0x30 entry was hit twice by jumps: strongly taken to 0x10
    set_id(1'b1, 32'h0040_0034, 2'b01, 1'b0, 1'b0, 32'h0040_0030, 32'h0);
    tick(); clear_id(); exp_cnt++;
    #1;
    check_eq("st_pc", pc, 32'h0040_0030);
    check_eq("st_pred", if_pred_taken, BTB ? 32'd1 : 32'd0);
    check_eq("st_pcnext", PC_next, BTB ? 32'h0040_0010 : 32'h0040_0034);
    check_eq("st_cnt", mispredict_cnt, 32'(exp_cnt % 16));

    // 16 back-to-back redirects wrap the 4-bit counter to its previous value
    for (int i = 0; i < 16; i++) begin
      set_id(1'b1, 32'h0040_0050, 2'b10, 1'b0, 1'b0, 32'h0,
             (i % 2 == 1) ? 32'h0040_0300 : 32'h0040_0200);
      tick();
    end
    clear_id();
    #1;
    check_eq("wrap_cnt", mispredict_cnt, 32'(exp_cnt % 16));
    check_eq("wrap_pc", pc, 32'h0040_0300);

    // reset mid-operation beats stall and redirect
    stall = 1'b1; reset = 1'b1;
    set_id(1'b1, 32'h0040_0050, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0040_0500);
    #1;
    check_eq("mrst_ifid", IFIDFlush, 0);
    check_eq("mrst_idex", IDEXFlush, 0);
    tick();
    reset = 1'b0; stall = 1'b0; clear_id(); exp_cnt = 0;
    #1;
    check_eq("mrst_pc", pc, 32'h0040_0000);
    check_eq("mrst_cnt", mispredict_cnt, 0);
    set_id(1'b1, 32'h0040_0044, 2'b01, 1'b0, 1'b0, 32'h0040_0030, 32'h0);
    tick(); clear_id(); exp_cnt++;
    #1;
    check_eq("mrst_cleared_pc", pc, 32'h0040_0030);
    check_eq("mrst_cleared_pred", if_pred_taken, 0);
    check_eq("mrst_cleared_pcnext", PC_next, 32'h0040_0034);
    check_eq("mrst_cleared_cnt", mispredict_cnt, 32'(exp_cnt % 16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
